count_capture_ctrl: RTL and testbench

- Controller for the free-running counter and its 16-entry sample memory.
- Owns the counter, arms on request and triggers when the count equals a programmed value.
- Captures a programmed number of consecutive count samples into the memory, then streams them out over a valid/ready port.
- Sits between the testbench/Verisocks-driven control stimulus and the counter/memory datapath; replaces ad-hoc pointer handling with one sequencer.

---
 rtl/count_capture_pkg.sv | 22 ++
 rtl/capture_mem.sv | 37 +++
 rtl/count_capture_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_count_capture_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_capture_pkg.sv
// Shared types and defaults for the count capture sequencer.
package count_capture_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 16;

    // A request of 0 selects a full-depth capture.
    localparam int N_FULL_CODE = 0;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READ
    } state_t;

    // Requests of 0 and requests above the memory depth both mean a full-depth capture.
    function automatic int clamp_n(input int ns, input int depth);
        return (ns == N_FULL_CODE || ns > depth) ? depth : ns;
    endfunction

endpackage

// File: rtl/capture_mem.sv
// Sample memory: one write port and one registered read port.
// The array itself is not reset; only the read register clears on reset.
module capture_mem #(
    parameter  int CNT_W = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic             i_re,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [CNT_W-1:0] o_rdata
);

    logic [CNT_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/count_capture_ctrl.sv
// Free-running counter plus trigger/capture/readout sequencer for a small sample memory.
// Optional CNT_WRAP_IRQ_EN adds a wrap pulse output and a saturating wrap counter.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | waiting for count == trig_val (with cnt_en)
// CAPTURE | writing consecutive counts into memory
// READ    | streaming captured samples over rd_valid/rd_ready
module count_capture_ctrl
    import count_capture_pkg::*;
#(
    parameter  int CNT_W = CNT_W_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             arm,
    input  logic             abort,
    input  logic [CNT_W-1:0] trig_val,
    input  logic [PTR_W:0]   num_samples,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_last
`ifdef CNT_WRAP_IRQ_EN
    ,
    output logic             wrap_irq,
    output logic [7:0]       wrap_cnt
`endif
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] r_n_m1;
    logic [PTR_W-1:0] w_n_m1_nxt;
    logic [PTR_W-1:0] w_n_m1_req;
    logic             r_rd_valid;
    logic             w_rd_valid_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_mem_we;
    logic [PTR_W-1:0] w_mem_waddr;
    logic             w_mem_re;
    logic [PTR_W-1:0] w_mem_raddr;
    logic             w_trig;
    logic             w_xfer;
    logic             w_arm_ok;
    logic             w_rd_last;

    // N is held as N-1 so it fits the pointer width even at full depth.
    assign w_n_m1_req = PTR_W'(clamp_n(int'(num_samples), DEPTH) - 1);
    assign w_trig     = cnt_en && (r_count == trig_val);
    assign w_xfer     = r_rd_valid && rd_ready;
    assign w_arm_ok   = (r_state == IDLE) && arm && !abort;
    assign w_rd_last  = r_rd_valid && (r_rd_ptr == r_n_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (cnt_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_n_m1     <= PTR_W'(DEPTH - 1);
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_n_m1     <= w_n_m1_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_n_m1_nxt     = r_n_m1;
        w_rd_valid_nxt = r_rd_valid;
        w_done_nxt     = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_waddr    = r_wr_ptr;
        w_mem_re       = 1'b0;
        w_mem_raddr    = r_rd_ptr + PTR_W'(1);
        if (abort) begin
            w_state_nxt    = IDLE;
            w_rd_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arm_ok) begin
                        w_state_nxt  = ARMED;
                        w_n_m1_nxt   = w_n_m1_req;
                        w_wr_ptr_nxt = '0;
                    end
                end
                ARMED: begin
                    if (w_trig) begin
                        w_mem_we     = 1'b1;
                        w_mem_waddr  = '0;
                        w_wr_ptr_nxt = PTR_W'(1);
                        w_state_nxt  = (r_n_m1 == '0) ? READ : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cnt_en) begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                        if (r_wr_ptr == r_n_m1) begin
                            w_state_nxt = READ;
                        end
                    end
                end
                READ: begin
                    // First READ cycle preloads sample 0; valid rises on the next edge.
                    if (!r_rd_valid) begin
                        w_mem_re       = 1'b1;
                        w_mem_raddr    = '0;
                        w_rd_ptr_nxt   = '0;
                        w_rd_valid_nxt = 1'b1;
                    end else if (w_xfer) begin
                        if (w_rd_last) begin
                            w_state_nxt    = IDLE;
                            w_rd_valid_nxt = 1'b0;
                            w_done_nxt     = 1'b1;
                        end else begin
                            w_mem_re     = 1'b1;
                            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    capture_mem #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (r_count),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (rd_data)
    );

    assign count    = r_count;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign rd_valid = r_rd_valid;
    assign rd_last  = w_rd_last;

`ifdef CNT_WRAP_IRQ_EN
    logic       r_wrap_irq;
    logic [7:0] r_wrap_cnt;
    logic       w_wrap;

    assign w_wrap = cnt_en && (r_count == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_irq <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            r_wrap_irq <= w_wrap;
            if (w_arm_ok) begin
                r_wrap_cnt <= '0;
            end else if (w_wrap && (r_wrap_cnt != 8'hFF)) begin
                r_wrap_cnt <= r_wrap_cnt + 8'd1;
            end
        end
    end

    assign wrap_irq = r_wrap_irq;
    assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_count_capture_ctrl.sv
// Self-checking bench for count_capture_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_count_capture_ctrl;

    logic       clk;
    logic       rst;
    logic       cnt_en;
    logic       arm;
    logic       abort;
    logic [7:0] trig_val;
    logic [4:0] num_samples;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_last;
`ifdef CNT_WRAP_IRQ_EN
    logic       wrap_irq;
    logic [7:0] wrap_cnt;
`endif

    count_capture_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_en      (cnt_en),
        .arm         (arm),
        .abort       (abort),
        .trig_val    (trig_val),
        .num_samples (num_samples),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last)
`ifdef CNT_WRAP_IRQ_EN
        ,
        .wrap_irq    (wrap_irq),
        .wrap_cnt    (wrap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: phases of a capture job, samples kept as a plain queue.
    localparam int P_IDLE = 0, P_ARMED = 1, P_COLLECT = 2, P_LATENCY = 3, P_DRAIN = 4;
    bit m_live = 0;
    int m_count, m_phase, m_n, m_idx, m_ns;
    bit m_valid, m_done, m_arm_ok;
    int m_q[$];
    bit m_wrap_irq;
    int m_wrap_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_count = 0; m_phase = P_IDLE; m_valid = 0; m_done = 0;
            m_idx = 0; m_n = 16; m_q.delete(); m_wrap_irq = 0; m_wrap_cnt = 0;
        end else if (m_live) begin
            m_arm_ok = (m_phase == P_IDLE) && arm && !abort;
            m_done = 0;
            if (abort) begin
                m_phase = P_IDLE;
                m_valid = 0;
            end else begin
                case (m_phase)
                    P_IDLE: if (arm) begin
                        m_ns = int'(num_samples);
                        m_n = (m_ns == 0 || m_ns > 16) ? 16 : m_ns;
                        m_q.delete();
                        m_phase = P_ARMED;
                    end
                    P_ARMED: if (cnt_en && m_count == int'(trig_val)) begin
                        m_q.push_back(m_count);
                        m_phase = (m_n == 1) ? P_LATENCY : P_COLLECT;
                    end
                    P_COLLECT: if (cnt_en) begin
                        m_q.push_back(m_count);
                        if (m_q.size() == m_n) m_phase = P_LATENCY;
                    end
                    P_LATENCY: begin
                        m_valid = 1; m_idx = 0; m_phase = P_DRAIN;
                    end
                    P_DRAIN: if (rd_ready) begin
                        if (m_idx == m_n - 1) begin
                            m_phase = P_IDLE; m_valid = 0; m_done = 1;
                        end else begin
                            m_idx++;
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
            m_wrap_irq = cnt_en && (m_count == 255);
            if (m_arm_ok) m_wrap_cnt = 0;
            else if (m_wrap_irq && m_wrap_cnt < 255) m_wrap_cnt++;
            if (cnt_en) m_count = (m_count + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("count", 32'(count), 32'(m_count));
            chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
            chk("done", 32'(done), 32'(m_done));
            chk("rd_valid", 32'(rd_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rd_data", 32'(rd_data), 32'(m_q[m_idx]));
                chk("rd_last", 32'(rd_last), 32'(m_idx == m_n - 1));
            end
`ifdef CNT_WRAP_IRQ_EN
            chk("wrap_irq", 32'(wrap_irq), 32'(m_wrap_irq));
            chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap_cnt));
`endif
        end
    end

    // Record every completed handshake.
    int obs_d[$];
    int obs_l[$];
    always @(posedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            obs_d.push_back(int'(rd_data));
            obs_l.push_back(int'(rd_last));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; arm = 0; abort = 0; cnt_en = 0; rd_ready = 0;
        step(2);
        rst = 0;
        obs_d.delete();
        obs_l.delete();
    endtask

    task automatic arm_job(input int tv, input int ns);
        trig_val = 8'(tv);
        num_samples = 5'(ns);
        arm = 1;
        step(1);
        arm = 0;
    endtask

    task automatic wait_count(input int v);
        for (int i = 0; i < 300 && m_count != v; i++) step(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (done === 1'b1) seen = 1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step(1);
            if (rd_valid === 1'b1) seen = 1;
        end
        chk({name, "_valid_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic chk_obs(input string name, input int exp[$]);
        chk({name, "_n"}, 32'(obs_d.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_d.size(); i++) begin
            chk({name, "_data"}, 32'(obs_d[i]), 32'(exp[i]));
            chk({name, "_last"}, 32'(obs_l[i]), 32'(i == exp.size() - 1));
        end
    endtask

    int exp_q[$];

    initial begin
        rst = 1; cnt_en = 0; arm = 0; abort = 0; trig_val = 0; num_samples = 0; rd_ready = 0;

        // Free-running counter and wrap.
        step(1);
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        cnt_en = 1;
        step(256);
        chk("wrap_to_0", 32'(count), 32'd0);
        step(44);
        chk("count_300", 32'(count), 32'd44);
`ifdef CNT_WRAP_IRQ_EN
        step(300);
        chk("wrap_cnt_600", 32'(wrap_cnt), 32'd2);
`endif

        // Basic capture of four, with an ignored arm while armed.
        do_reset();
        cnt_en = 1; rd_ready = 1;
        wait_count(3);
        arm_job(10, 4);
        step(3);
        arm = 1; step(1); arm = 0;
        wait_done("t2", 60);
        exp_q = '{10, 11, 12, 13};
        chk_obs("t2", exp_q);
        step(1);
        chk("t2_idle", 32'(busy), 32'd0);

        // Full depth through the wrap, consumer stalling every other cycle.
        do_reset();
        cnt_en = 1;
        arm_job(254, 0);
        begin
            bit seen = 0;
            for (int i = 0; i < 800 && !seen; i++) begin
                rd_ready = ~rd_ready;
                step(1);
                if (done === 1'b1) seen = 1;
            end
            chk("t3_done_seen", 32'(seen), 32'd1);
        end
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back((254 + i) % 256);
        chk_obs("t3", exp_q);

        // Counter paused mid-capture.
        do_reset();
        cnt_en = 1; rd_ready = 1;
        arm_job(50, 6);
        wait_count(52);
        cnt_en = 0;
        step(3);
        cnt_en = 1;
        wait_done("t4", 60);
        exp_q = '{50, 51, 52, 53, 54, 55};
        chk_obs("t4", exp_q);

        // Abort during capture, with a simultaneous arm.
        do_reset();
        cnt_en = 1; rd_ready = 1;
        arm_job(20, 8);
        wait_count(23);
        abort = 1; arm = 1;
        step(1);
        abort = 0; arm = 0;
        chk("t5a_busy", 32'(busy), 32'd0);
        chk("t5a_valid", 32'(rd_valid), 32'd0);
        step(1);
        chk("t5a_arm_ignored", 32'(busy), 32'd0);
        step(20);
        chk("t5a_no_xfer", 32'(obs_d.size()), 32'd0);

        // Abort during readout with data pending.
        rd_ready = 0;
        arm_job(60, 4);
        wait_valid("t5b", 60);
        step(2);
        chk("t5b_hold_data", 32'(rd_data), 32'd60);
        chk("t5b_hold_last", 32'(rd_last), 32'd0);
        abort = 1;
        step(1);
        abort = 0;
        chk("t5b_valid", 32'(rd_valid), 32'd0);
        chk("t5b_last", 32'(rd_last), 32'd0);
        chk("t5b_busy", 32'(busy), 32'd0);
        step(10);

        // Single-sample capture.
        do_reset();
        cnt_en = 1; rd_ready = 1;
        arm_job(7, 1);
        wait_done("t6", 40);
        exp_q = '{7};
        chk_obs("t6", exp_q);

        // Oversized request clamps to full depth.
        do_reset();
        cnt_en = 1; rd_ready = 1;
        arm_job(100, 20);
        wait_done("t7", 200);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(100 + i);
        chk_obs("t7", exp_q);

        // Reset in the middle of a readout.
        do_reset();
        cnt_en = 1; rd_ready = 0;
        arm_job(5, 4);
        wait_valid("t8", 40);
        rst = 1;
        step(1);
        chk("t8_valid", 32'(rd_valid), 32'd0);
        chk("t8_count", 32'(count), 32'd0);
        chk("t8_busy", 32'(busy), 32'd0);
        chk("t8_rd_data", 32'(rd_data), 32'd0);
        rst = 0;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
